multicycle_controller: RTL and testbench

Finite-state controller that sequences the shared multi-cycle RV32I-subset datapath: one memory for instructions and data, one ALU reused for PC increment, address and branch-target computation, plus instruction/data/ALUOut/OldPC registers. It decodes the instruction register fields and the ALU flags each cycle. It drives every write enable and mux select of that datapath. Supported instructions: lw, sw, R-type, I-type ALU, beq/bne/blt/bge, jal, jalr, lui.

---
 rtl/multicycle_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main FSM for the shared multi-cycle RV32I-subset datapath.
// It drives every write enable and mux select from the current state and the decoded instruction fields.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       neg,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       done
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALR1    = 4'd10,
        S_JUMP     = 4'd11,
        S_LUI      = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    state_t state, next_state;

    logic pc_write, ir_write, mem_write, reg_write, halted;

    // Only a real R-type with funct7=0100000 subtracts; addi never does, whatever its immediate bits.
    function automatic logic [2:0] funct_alu(input logic [6:0] f_op,
                                             input logic [2:0] f3,
                                             input logic [6:0] f7);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = (f_op == OP_R && f7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
            3'b111:  ctl = ALU_AND;
            3'b110:  ctl = ALU_OR;
            3'b100:  ctl = ALU_XOR;
            3'b010:  ctl = ALU_SLT;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    function automatic logic [2:0] decode_imm(input logic [6:0] f_op);
        logic [2:0] imm;
        case (f_op)
            OP_SW:   imm = IMM_S;
            OP_BR:   imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            OP_LUI:  imm = IMM_U;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       z,
                                          input logic       n);
        logic taken;
        case (f3)
            3'b000:  taken = z;
            3'b001:  taken = !z;
            3'b100:  taken = n;
            3'b101:  taken = !n;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= next_state;
    end

    // NOTE: every output gets a default before the case, so no path leaves a value held (no latch).
    always_comb begin
        next_state = state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;

        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                ALUSrcB    = SRCB_4;
                ResultSrc  = RES_ALU;
                pc_write   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = decode_imm(op);
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_BR:        next_state = S_BRANCH;
                    OP_JAL:       next_state = S_JUMP;
                    OP_JALR:      next_state = S_JALR1;
                    OP_LUI:       next_state = S_LUI;
                    default:      next_state = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = (op == OP_SW) ? IMM_S : IMM_I;
                next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                mem_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RD1;
                ALUControl = funct_alu(op, func3, func7);
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = funct_alu(op, func3, func7);
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                ALUControl = ALU_SUB;
                pc_write   = branch_taken(func3, zero, neg);
                next_state = S_FETCH;
            end
            S_JALR1: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                next_state = S_JUMP;
            end
            S_JUMP: begin
                // Jump target already sits in ALUOut; ALU forms the link value OldPC+4.
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_4;
                pc_write   = 1'b1;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_U;
                ALUControl = ALU_PASS;
                next_state = S_ALUWB;
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Enables are masked by reset so the FETCH state cannot pulse them while reset is held.
    assign PCWrite  = pc_write  & rst;
    assign IRWrite  = ir_write  & rst;
    assign MemWrite = mem_write & rst;
    assign RegWrite = reg_write & rst;
    assign done     = halted    & rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle control vectors compared against
// a cycle-table model of each instruction class, with randomized fields and ALU flags.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] func3 = 3'd0;
    logic [6:0] func7 = 7'd0;
    logic       zero = 1'b0;
    logic       neg = 1'b0;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, done;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc, ALUControl;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       mw;
        logic       rw;
        logic       done;
        logic       adr;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [2:0] imm;
        logic [2:0] alu;
    } ctl_t;

    typedef enum int {C_LW, C_SW, C_R, C_I, C_BR, C_JAL, C_JALR, C_LUI, C_HALT} cls_e;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .neg(neg),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic ctl_t observed();
        ctl_t a;
        a = '{pcw: PCWrite, irw: IRWrite, mw: MemWrite, rw: RegWrite, done: done,
              adr: AdrSrc, srca: ALUSrcA, srcb: ALUSrcB, res: ResultSrc,
              imm: ImmSrc, alu: ALUControl};
        return a;
    endfunction

    function automatic int cycles_of(cls_e c);
        case (c)
            C_LW, C_JALR: return 5;
            C_BR:         return 3;
            default:      return 4;
        endcase
    endfunction

    function automatic logic [6:0] op_of(cls_e c);
        case (c)
            C_LW:    return 7'b0000011;
            C_SW:    return 7'b0100011;
            C_R:     return 7'b0110011;
            C_I:     return 7'b0010011;
            C_BR:    return 7'b1100011;
            C_JAL:   return 7'b1101111;
            C_JALR:  return 7'b1100111;
            C_LUI:   return 7'b0110111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(cls_e c, logic [2:0] f3, logic [6:0] f7);
        if (f3 == 3'b000) return (c == C_R && f7 == 7'b0100000) ? 3'b001 : 3'b000;
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b100) return 3'b111;
        if (f3 == 3'b010) return 3'b101;
        return 3'b000;
    endfunction

    function automatic logic taken_of(logic [2:0] f3, logic z, logic n);
        if (f3 == 3'b000) return z;
        if (f3 == 3'b001) return !z;
        if (f3 == 3'b100) return n;
        if (f3 == 3'b101) return !n;
        return 1'b0;
    endfunction

    // Expected control vector for cycle idx (0-based) of an instruction of class c.
    function automatic ctl_t expect_ctl(cls_e c, int idx, logic [2:0] f3, logic [6:0] f7,
                                        logic z, logic n);
        ctl_t e;
        ctl_t wb;
        ctl_t jump;
        e = '0;
        wb = '0;
        wb.rw = 1'b1;
        jump = '0;
        jump.srca = 2'b01; jump.srcb = 2'b10; jump.pcw = 1'b1;
        if (idx == 0) begin
            e.irw = 1'b1; e.pcw = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
        end else if (idx == 1) begin
            e.srca = 2'b01; e.srcb = 2'b01;
            case (c)
                C_SW:    e.imm = 3'b001;
                C_BR:    e.imm = 3'b010;
                C_JAL:   e.imm = 3'b011;
                C_LUI:   e.imm = 3'b100;
                default: e.imm = 3'b000;
            endcase
        end else begin
            case (c)
                C_LW: begin
                    if (idx == 2) begin e.srca = 2'b10; e.srcb = 2'b01; end
                    else if (idx == 3) e.adr = 1'b1;
                    else begin e.res = 2'b01; e.rw = 1'b1; end
                end
                C_SW: begin
                    if (idx == 2) begin e.srca = 2'b10; e.srcb = 2'b01; e.imm = 3'b001; end
                    else begin e.adr = 1'b1; e.mw = 1'b1; end
                end
                C_R: begin
                    if (idx == 2) begin e.srca = 2'b10; e.alu = alu_of(c, f3, f7); end
                    else e = wb;
                end
                C_I: begin
                    if (idx == 2) begin e.srca = 2'b10; e.srcb = 2'b01; e.alu = alu_of(c, f3, f7); end
                    else e = wb;
                end
                C_BR: begin
                    e.srca = 2'b10; e.alu = 3'b001; e.pcw = taken_of(f3, z, n);
                end
                C_JAL: e = (idx == 2) ? jump : wb;
                C_JALR: begin
                    if (idx == 2) begin e.srca = 2'b10; e.srcb = 2'b01; end
                    else if (idx == 3) e = jump;
                    else e = wb;
                end
                C_LUI: begin
                    if (idx == 2) begin e.srcb = 2'b01; e.imm = 3'b100; e.alu = 3'b100; end
                    else e = wb;
                end
                default: e.done = 1'b1;
            endcase
        end
        return e;
    endfunction

    function automatic ctl_t reset_vector();
        ctl_t e;
        e = '0;
        e.srcb = 2'b10;
        e.res  = 2'b10;
        return e;
    endfunction

    task automatic load(input cls_e c, input logic [2:0] f3, input logic [6:0] f7);
        op = op_of(c);
        func3 = f3;
        func7 = f7;
    endtask

    // Advance to the middle of the next cycle; flags are randomized unless forced.
    task automatic step(input bit rnd, input logic z, input logic n);
        @(negedge clk);
        if (rnd) begin
            zero = 1'($urandom);
            neg  = 1'($urandom);
        end else begin
            zero = z;
            neg  = n;
        end
        #1;
    endtask

    task automatic test_reset();
        ctl_t exp_v;
        exp_v = reset_vector();
        repeat (2) begin
            @(negedge clk);
            op = 7'($urandom);
            #1;
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL reset_hold: got %h expected %h", observed(), exp_v);
            end
        end
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_lw();
        ctl_t exp_v;
        load(C_LW, 3'b010, 7'd0);
        for (int i = 0; i < cycles_of(C_LW); i++) begin
            step(1, 0, 0);
            exp_v = expect_ctl(C_LW, i, func3, func7, zero, neg);
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL lw cycle %0d: got %h expected %h", i, observed(), exp_v);
            end
        end
    endtask

    task automatic test_funct();
        cls_e       cls_t [8] = '{C_R, C_R, C_I, C_R, C_R, C_I, C_R, C_I};
        logic [2:0] f3_t  [8] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b010, 3'b101};
        logic [6:0] f7_t  [8] = '{7'b0100000, 7'd0, 7'b0100000, 7'd0, 7'd0, 7'd0, 7'd0, 7'b0100000};
        ctl_t exp_v;
        for (int k = 0; k < 8; k++) begin
            load(cls_t[k], f3_t[k], f7_t[k]);
            for (int i = 0; i < cycles_of(cls_t[k]); i++) begin
                step(1, 0, 0);
                exp_v = expect_ctl(cls_t[k], i, func3, func7, zero, neg);
                checks++;
                if (observed() !== exp_v) begin
                    errors++;
                    $display("FAIL funct case %0d cycle %0d: got %h expected %h", k, i, observed(), exp_v);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3_t [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b000, 3'b011};
        logic       z_t  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       n_t  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ctl_t exp_v;
        for (int k = 0; k < 6; k++) begin
            load(C_BR, f3_t[k], 7'd0);
            for (int i = 0; i < cycles_of(C_BR); i++) begin
                step(i != 2, z_t[k], n_t[k]);
                exp_v = expect_ctl(C_BR, i, func3, func7, zero, neg);
                checks++;
                if (observed() !== exp_v) begin
                    errors++;
                    $display("FAIL branch case %0d cycle %0d: got %h expected %h", k, i, observed(), exp_v);
                end
            end
        end
    endtask

    task automatic test_jumps();
        cls_e cls_t [3] = '{C_JAL, C_JALR, C_LUI};
        ctl_t exp_v;
        for (int k = 0; k < 3; k++) begin
            load(cls_t[k], 3'($urandom), 7'($urandom));
            for (int i = 0; i < cycles_of(cls_t[k]); i++) begin
                step(1, 0, 0);
                exp_v = expect_ctl(cls_t[k], i, func3, func7, zero, neg);
                checks++;
                if (observed() !== exp_v) begin
                    errors++;
                    $display("FAIL jump case %0d cycle %0d: got %h expected %h", k, i, observed(), exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_midway();
        ctl_t exp_v;
        load(C_SW, 3'b010, 7'd0);
        for (int i = 0; i < cycles_of(C_SW); i++) begin
            step(1, 0, 0);
            exp_v = expect_ctl(C_SW, i, func3, func7, zero, neg);
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL sw_pre_reset cycle %0d: got %h expected %h", i, observed(), exp_v);
            end
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || observed() !== reset_vector()) begin
            errors++;
            $display("FAIL reset_in_memwrite: got %h expected %h", observed(), reset_vector());
        end
        @(posedge clk);
        #1;
        checks++;
        if (observed() !== reset_vector()) begin
            errors++;
            $display("FAIL reset_across_edge: got %h expected %h", observed(), reset_vector());
        end
        #1 rst = 1'b1;
        load(C_R, 3'b000, 7'b0100000);
        for (int i = 0; i < cycles_of(C_R); i++) begin
            step(1, 0, 0);
            exp_v = expect_ctl(C_R, i, func3, func7, zero, neg);
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL after_reset cycle %0d: got %h expected %h", i, observed(), exp_v);
            end
        end
    endtask

    task automatic test_random();
        cls_e c;
        ctl_t exp_v;
        for (int k = 0; k < 60; k++) begin
            c = cls_e'($urandom_range(0, 7));
            load(c, 3'($urandom), ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom));
            for (int i = 0; i < cycles_of(c); i++) begin
                step(1, 0, 0);
                exp_v = expect_ctl(c, i, func3, func7, zero, neg);
                checks++;
                if (observed() !== exp_v) begin
                    errors++;
                    $display("FAIL random instr %0d class %0d cycle %0d: got %h expected %h",
                             k, c, i, observed(), exp_v);
                end
            end
        end
    endtask

    task automatic test_halt(input bit zero_op);
        logic [6:0] bad;
        ctl_t exp_v;
        bad = 7'b0000000;
        if (!zero_op) begin
            do bad = 7'($urandom);
            while (bad == 7'b0000011 || bad == 7'b0100011 || bad == 7'b0110011 ||
                   bad == 7'b0010011 || bad == 7'b1100011 || bad == 7'b1101111 ||
                   bad == 7'b1100111 || bad == 7'b0110111);
        end
        op = bad;
        func3 = 3'($urandom);
        func7 = 7'($urandom);
        for (int i = 0; i < 14; i++) begin
            step(1, 0, 0);
            exp_v = expect_ctl(C_HALT, i, func3, func7, zero, neg);
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL halt op %b cycle %0d: got %h expected %h", bad, i, observed(), exp_v);
            end
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (observed() !== reset_vector()) begin
            errors++;
            $display("FAIL halt_reset: got %h expected %h", observed(), reset_vector());
        end
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_funct();
        test_branch();
        test_jumps();
        test_halt(1'b1);
        test_reset_midway();
        test_random();
        test_halt(1'b0);
        test_lw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
